// File: rtl/raster_pkg.sv
// raster_pkg
//   Shared types and constants for the raster tile sequencer slice.
//   - TILE_LOG2_DEF : default log2 of the tile edge (32x32 tile)
//   - CNT_W_DEF     : default performance-counter width
//   - A_W/B_W/W_W   : edge-function coefficient widths (x-step, y-step, origin value)
//   - tri_setup_t   : packed A/B/W triples for the three triangle edges
//   - seq_state_e   : sequencer FSM states
package raster_pkg;

  localparam int TILE_LOG2_DEF = 5;
  localparam int CNT_W_DEF     = 32;

  localparam int A_W = 19;
  localparam int B_W = 24;
  localparam int W_W = 32;

  // Edge n is evaluated as w_n + a_n*x + b_n*y by the rasterizer; the
  // sequencer only latches and forwards these values.
  typedef struct packed {
    logic signed [A_W-1:0] a01;
    logic signed [A_W-1:0] a12;
    logic signed [A_W-1:0] a20;
    logic signed [B_W-1:0] b01;
    logic signed [B_W-1:0] b12;
    logic signed [B_W-1:0] b20;
    logic signed [W_W-1:0] w0;
    logic signed [W_W-1:0] w1;
    logic signed [W_W-1:0] w2;
  } tri_setup_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/raster_tile_sequencer_if.sv
// raster_tile_sequencer_if
//   Bundles the three channels around the tile sequencer:
//   - command channel  : cmd_valid/cmd_ready handshake, cmd_clear, cmd_a*/b*/w*
//   - rasterizer side  : rs_start/rs_enable/rs_clear, latched rs_a*/b*/w*,
//                        rs_x/rs_y coordinate, rs_raster_px/rs_clear_px results
//   - tile-buffer side : wr_en/wr_addr/wr_cover stream and done pulse
//   modport master : the sequencer
//   modport slave  : the environment (command source, rasterizer, tile buffer)
interface raster_tile_sequencer_if
  import raster_pkg::*;
#(
  parameter int TILE_LOG2 = TILE_LOG2_DEF
) ();

  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_clear;
  logic signed [A_W-1:0] cmd_a01, cmd_a12, cmd_a20;
  logic signed [B_W-1:0] cmd_b01, cmd_b12, cmd_b20;
  logic signed [W_W-1:0] cmd_w0, cmd_w1, cmd_w2;

  // rasterizer channel
  logic                  rs_start;
  logic                  rs_enable;
  logic                  rs_clear;
  logic signed [A_W-1:0] rs_a01, rs_a12, rs_a20;
  logic signed [B_W-1:0] rs_b01, rs_b12, rs_b20;
  logic signed [W_W-1:0] rs_w0, rs_w1, rs_w2;
  logic [TILE_LOG2-1:0]  rs_x, rs_y;
  logic                  rs_raster_px;
  logic                  rs_clear_px;

  // tile-buffer write stream
  logic                   wr_en;
  logic [2*TILE_LOG2-1:0] wr_addr;
  logic                   wr_cover;
  logic                   done;

  modport master (
    input  cmd_valid, cmd_clear,
    input  cmd_a01, cmd_a12, cmd_a20, cmd_b01, cmd_b12, cmd_b20, cmd_w0, cmd_w1, cmd_w2,
    output cmd_ready,
    output rs_start, rs_enable, rs_clear,
    output rs_a01, rs_a12, rs_a20, rs_b01, rs_b12, rs_b20, rs_w0, rs_w1, rs_w2,
    output rs_x, rs_y,
    input  rs_raster_px, rs_clear_px,
    output wr_en, wr_addr, wr_cover, done
  );

  modport slave (
    output cmd_valid, cmd_clear,
    output cmd_a01, cmd_a12, cmd_a20, cmd_b01, cmd_b12, cmd_b20, cmd_w0, cmd_w1, cmd_w2,
    input  cmd_ready,
    input  rs_start, rs_enable, rs_clear,
    input  rs_a01, rs_a12, rs_a20, rs_b01, rs_b12, rs_b20, rs_w0, rs_w1, rs_w2,
    input  rs_x, rs_y,
    output rs_raster_px, rs_clear_px,
    input  wr_en, wr_addr, wr_cover, done
  );

endinterface

// File: rtl/raster_scan_counter.sv
// raster_scan_counter
//   X/Y raster-order walker over a 2^W square tile, x fastest.
//   Ports:
//     clk, rst : clock and synchronous active-high reset (clears to 0,0)
//     clr      : synchronous clear back to (0,0)
//     inc      : advance one pixel; x wraps to 0 carrying into y
//     x, y     : current coordinate
//     last     : high while at (max,max), the final pixel of the tile
module raster_scan_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);

  logic [W-1:0] x_reg, y_reg;

  // {y,x} treated as one 2W-bit counter gives the x-wrap/y-carry for free,
  // and the whole thing wraps back to (0,0) after the last pixel.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (inc) begin
      {y_reg, x_reg} <= {y_reg, x_reg} + 1'b1;
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (&x_reg) & (&y_reg);

endmodule

// File: rtl/raster_tile_sequencer.sv
// raster_tile_sequencer
//   Command-driven controller for one 2^TILE_LOG2-square tile rasterizer.
//   Accepts a triangle-setup or tile-clear command per handshake, latches the
//   edge coefficients, pulses rs_start, walks every pixel of the tile with
//   rs_enable held, and re-times the rasterizer's 1-cycle-late result into a
//   tile-buffer write stream ({y,x} address, cover flag, done on last write).
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     bus (master)      : command / rasterizer / tile-buffer channels
//     perf_tris/perf_px : saturating completed-command and covered-pixel
//                         counters, present only when RASTER_PERF_EN is defined
//   Build option: RASTER_PERF_EN adds the performance counters.
module raster_tile_sequencer
  import raster_pkg::*;
#(
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  raster_tile_sequencer_if.master  bus
`ifdef RASTER_PERF_EN
  ,
  output logic [CNT_W-1:0]         perf_tris,
  output logic [CNT_W-1:0]         perf_px
`endif
);

  seq_state_e state_reg, state_next;

  tri_setup_t cmd_setup;
  tri_setup_t setup_reg;
  logic       clear_reg;

  logic accept;
  logic cmd_ready_next, rs_start_next, rs_enable_next, done_next;
  logic cnt_clr, cnt_inc;

  logic [TILE_LOG2-1:0] scan_x, scan_y;
  logic                 scan_last;

  // Pixel coordinate delayed one cycle so it lines up with rs_*_px.
  logic                 px_valid_reg;
  logic [TILE_LOG2-1:0] px_x_reg, px_y_reg;

  assign cmd_setup = '{
    a01: bus.cmd_a01, a12: bus.cmd_a12, a20: bus.cmd_a20,
    b01: bus.cmd_b01, b12: bus.cmd_b12, b20: bus.cmd_b20,
    w0:  bus.cmd_w0,  w1:  bus.cmd_w1,  w2:  bus.cmd_w2
  };

  assign accept = bus.cmd_valid & (state_reg == IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready_next = 1'b0;
    rs_start_next  = 1'b0;
    rs_enable_next = 1'b0;
    done_next      = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready_next = 1'b1;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        rs_start_next = 1'b1;
        cnt_clr       = 1'b1;
        state_next    = SCAN;
      end
      SCAN: begin
        rs_enable_next = 1'b1;
        cnt_inc        = 1'b1;
        if (scan_last) state_next = DRAIN;
      end
      DRAIN: begin
        // The last pixel's result is written here, so done coincides with it.
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ command latch
  // Coefficients are data only and are deliberately left unreset; they are
  // always reloaded before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      setup_reg <= cmd_setup;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_reg <= 1'b0;
    end else if (accept) begin
      clear_reg <= bus.cmd_clear;
    end
  end

  // --------------------------------------------------------- X/Y walker
  raster_scan_counter #(
    .W (TILE_LOG2)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .x    (scan_x),
    .y    (scan_y),
    .last (scan_last)
  );

  // ------------------------------------------------------- write re-time
  // Reset drops any in-flight pixel: px_valid_reg clears, so no write and
  // (since the FSM leaves DRAIN) no done for the aborted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_valid_reg <= 1'b0;
      px_x_reg     <= '0;
      px_y_reg     <= '0;
    end else begin
      px_valid_reg <= rs_enable_next;
      px_x_reg     <= scan_x;
      px_y_reg     <= scan_y;
    end
  end

  // Clear commands write every pixel as background; raster commands write
  // only covered pixels.
  assign bus.wr_en    = px_valid_reg & (clear_reg | bus.rs_raster_px);
  assign bus.wr_cover = px_valid_reg & bus.rs_raster_px & ~clear_reg;
  assign bus.wr_addr  = {px_y_reg, px_x_reg};
  assign bus.done     = done_next;

  // The clear result carries no information beyond clear_reg itself.
  logic unused_clear_px;
  assign unused_clear_px = bus.rs_clear_px;

  // ------------------------------------------------------ outputs
  assign bus.cmd_ready = cmd_ready_next;
  assign bus.rs_start  = rs_start_next;
  assign bus.rs_enable = rs_enable_next;
  assign bus.rs_clear  = clear_reg & (state_reg != IDLE);
  assign bus.rs_x      = scan_x;
  assign bus.rs_y      = scan_y;

  assign bus.rs_a01 = setup_reg.a01;
  assign bus.rs_a12 = setup_reg.a12;
  assign bus.rs_a20 = setup_reg.a20;
  assign bus.rs_b01 = setup_reg.b01;
  assign bus.rs_b12 = setup_reg.b12;
  assign bus.rs_b20 = setup_reg.b20;
  assign bus.rs_w0  = setup_reg.w0;
  assign bus.rs_w1  = setup_reg.w1;
  assign bus.rs_w2  = setup_reg.w2;

`ifdef RASTER_PERF_EN
  // --------------------------------------------- saturating perf counters
  logic [CNT_W-1:0] perf_tris_reg, perf_px_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_tris_reg <= '0;
      perf_px_reg   <= '0;
    end else begin
      if (done_next && (perf_tris_reg != {CNT_W{1'b1}})) begin
        perf_tris_reg <= perf_tris_reg + 1'b1;
      end
      if (bus.wr_en && bus.wr_cover && (perf_px_reg != {CNT_W{1'b1}})) begin
        perf_px_reg <= perf_px_reg + 1'b1;
      end
    end
  end

  assign perf_tris = perf_tris_reg;
  assign perf_px   = perf_px_reg;
`endif

endmodule

// File: tb/tb_raster_tile_sequencer.sv
// tb_raster_tile_sequencer
//   Directed + randomized bench for raster_tile_sequencer. The bench plays the
//   rasterizer (edge functions from the DUT's latched coefficients) and checks
//   the write stream against a pixel-list model built from the commands sent.
module tb_raster_tile_sequencer;
  import raster_pkg::*;

  localparam int TL   = 5;
  localparam int EDGE = 1 << TL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_tile_sequencer_if #(.TILE_LOG2(TL)) bus ();

`ifdef RASTER_PERF_EN
  logic [31:0] perf_tris, perf_px;
`endif

  raster_tile_sequencer #(
    .TILE_LOG2 (TL),
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef RASTER_PERF_EN
    ,
    .perf_tris (perf_tris),
    .perf_px   (perf_px)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit exp_clear = 1'b0;

  // monitor records
  int start_q[$], en_q[$], done_q[$], acc_q[$];
  int wr_addr_q[$], wr_cyc_q[$];
  bit wr_cov_q[$];
  int notready = 0, clr_mis = 0, tally_tris = 0, tally_px = 0;

  // expected write stream
  int exp_addr[$], exp_cyc[$];
  bit exp_cov[$];

  function automatic bit pix_in(longint a0, longint b0, longint w0,
                                longint a1, longint b1, longint w1,
                                longint a2, longint b2, longint w2, int x, int y);
    return (w0 + a0 * x + b0 * y >= 0) && (w1 + a1 * x + b1 * y >= 0) &&
           (w2 + a2 * x + b2 * y >= 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // rasterizer stand-in: result one cycle after enable
  always @(posedge clk) begin
    if (rst) begin
      bus.rs_raster_px <= 1'b0;
      bus.rs_clear_px  <= 1'b0;
    end else begin
      bus.rs_raster_px <= bus.rs_enable && pix_in(
        $signed(bus.rs_a01), $signed(bus.rs_b01), $signed(bus.rs_w0),
        $signed(bus.rs_a12), $signed(bus.rs_b12), $signed(bus.rs_w1),
        $signed(bus.rs_a20), $signed(bus.rs_b20), $signed(bus.rs_w2),
        int'(bus.rs_x), int'(bus.rs_y));
      bus.rs_clear_px  <= bus.rs_enable && bus.rs_clear;
    end
  end

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready && !rst) acc_q.push_back(cyc);
    if (bus.rs_start) start_q.push_back(cyc);
    if (bus.rs_enable) begin
      en_q.push_back(cyc);
      if (bus.rs_clear !== exp_clear) clr_mis <= clr_mis + 1;
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.wr_en) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_cov_q.push_back(bus.wr_cover);
      wr_cyc_q.push_back(cyc);
    end
    if (!bus.cmd_ready) notready <= notready + 1;
    if (rst) begin
      tally_tris <= 0;
      tally_px   <= 0;
    end else begin
      if (bus.done) tally_tris <= tally_tris + 1;
      if (bus.wr_en && bus.wr_cover) tally_px <= tally_px + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic tri_setup_t rand_setup();
    tri_setup_t s;
    int r;
    r = int'($urandom_range(0, 16)) - 8;    s.a01 = r[A_W-1:0];
    r = int'($urandom_range(0, 16)) - 8;    s.a12 = r[A_W-1:0];
    r = int'($urandom_range(0, 16)) - 8;    s.a20 = r[A_W-1:0];
    r = int'($urandom_range(0, 16)) - 8;    s.b01 = r[B_W-1:0];
    r = int'($urandom_range(0, 16)) - 8;    s.b12 = r[B_W-1:0];
    r = int'($urandom_range(0, 16)) - 8;    s.b20 = r[B_W-1:0];
    r = int'($urandom_range(0, 400)) - 100; s.w0  = r;
    r = int'($urandom_range(0, 400)) - 100; s.w1  = r;
    r = int'($urandom_range(0, 400)) - 100; s.w2  = r;
    return s;
  endfunction

  task automatic drive_cmd(input bit clr, input tri_setup_t s);
    bus.cmd_clear = clr;
    bus.cmd_a01 = s.a01; bus.cmd_a12 = s.a12; bus.cmd_a20 = s.a20;
    bus.cmd_b01 = s.b01; bus.cmd_b12 = s.b12; bus.cmd_b20 = s.b20;
    bus.cmd_w0  = s.w0;  bus.cmd_w1  = s.w1;  bus.cmd_w2  = s.w2;
  endtask

  // Expected writes for a command accepted at t: pixel p (raster order) is
  // written at t+3+p; clear commands write all pixels uncovered.
  task automatic add_expected(input bit clr, input tri_setup_t s, input int t, input int max_cyc);
    for (int y = 0; y < EDGE; y++) begin
      for (int x = 0; x < EDGE; x++) begin
        int p;
        p = y * EDGE + x;
        if ((clr || pix_in($signed(s.a01), $signed(s.b01), $signed(s.w0),
                           $signed(s.a12), $signed(s.b12), $signed(s.w1),
                           $signed(s.a20), $signed(s.b20), $signed(s.w2), x, y))
            && (t + 3 + p <= max_cyc)) begin
          exp_addr.push_back(p);
          exp_cov.push_back(!clr);
          exp_cyc.push_back(t + 3 + p);
        end
      end
    end
  endtask

  task automatic check_writes(input string tag, input int from);
    int n, mism;
    n = wr_addr_q.size() - from;
    chk({tag, "_wr_count"}, n, exp_addr.size());
    mism = 0;
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      if (wr_addr_q[from+i] != exp_addr[i] || wr_cov_q[from+i] != exp_cov[i] ||
          wr_cyc_q[from+i] != exp_cyc[i]) mism++;
    end
    chk({tag, "_wr_stream_mismatches"}, mism, 0);
  endtask

  // Presents one command and returns its accept cycle (-1 on timeout).
  task automatic issue(input bit clr, input tri_setup_t s, output int t);
    @(posedge clk); #1;
    drive_cmd(clr, s);
    bus.cmd_valid = 1'b1;
    t = -1;
    for (int k = 0; k < 3000 && t < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) t = cyc;
    end
    if (t < 0) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    drive_cmd(1'($urandom_range(0, 1)), rand_setup());
  endtask

  task automatic run_single(input string tag, input bit clr, input tri_setup_t s);
    int t, s0, e0, d0, w0, n0, c0;
    s0 = start_q.size(); e0 = en_q.size(); d0 = done_q.size();
    w0 = wr_addr_q.size(); n0 = notready; c0 = clr_mis;
    exp_clear = clr;
    issue(clr, s, t);
    while (cyc < t + 1027) @(negedge clk);
    chk({tag, "_ready_at_T+1027"}, bus.cmd_ready, 1);
    chk({tag, "_start_count"}, start_q.size() - s0, 1);
    if (start_q.size() > s0) chk({tag, "_start_cycle"}, start_q[s0] - t, 1);
    chk({tag, "_enable_count"}, en_q.size() - e0, 1024);
    if (en_q.size() >= e0 + 1024) begin
      chk({tag, "_enable_first"}, en_q[e0] - t, 2);
      chk({tag, "_enable_last"}, en_q[e0+1023] - t, 1025);
    end
    chk({tag, "_done_count"}, done_q.size() - d0, 1);
    if (done_q.size() > d0) chk({tag, "_done_cycle"}, done_q[d0] - t, 1026);
    chk({tag, "_busy_cycles"}, notready - n0, 1026);
    chk({tag, "_rs_clear_errors"}, clr_mis - c0, 0);
    exp_addr.delete(); exp_cov.delete(); exp_cyc.delete();
    add_expected(clr, s, t, 32'h7fff_ffff);
    check_writes(tag, w0);
  endtask

  initial begin
    tri_setup_t s_tri, s1, s2;
    int t1, t2, a0, d0, w0, e0;

    bus.cmd_valid = 1'b0;
    drive_cmd(1'b0, '0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rs_start", bus.rs_start, 0);
    chk("rst_rs_enable", bus.rs_enable, 0);
    chk("rst_rs_clear", bus.rs_clear, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_cover", bus.wr_cover, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rs_xy", {bus.rs_y, bus.rs_x}, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
`ifdef RASTER_PERF_EN
    chk("rst_perf_tris", perf_tris, 0);
    chk("rst_perf_px", perf_px, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // idle for 100 cycles
    a0 = start_q.size(); w0 = wr_addr_q.size(); d0 = notready;
    repeat (100) @(negedge clk);
    chk("idle_starts", start_q.size() - a0, 0);
    chk("idle_writes", wr_addr_q.size() - w0, 0);
    chk("idle_not_ready", notready - d0, 0);

    // right triangle (0,0),(31,0),(0,31): 31-x-y>=0, x>=0, y>=0
    s_tri = '0;
    s_tri.a01 = -19'sd1; s_tri.b01 = -24'sd1; s_tri.w0 = 32'sd31;
    s_tri.a12 = 19'sd1;
    s_tri.b20 = 24'sd1;
    w0 = wr_addr_q.size();
    run_single("tri", 1'b0, s_tri);
    chk("tri_528_writes", wr_addr_q.size() - w0, 528);

    // tile clear with arbitrary coefficients
    run_single("clear", 1'b1, rand_setup());

    // random triangles
    for (int i = 0; i < 3; i++) run_single($sformatf("rand%0d", i), 1'b0, rand_setup());

    // back-to-back with cmd_valid held, plus a mid-scan glitch
    s1 = rand_setup(); s2 = rand_setup();
    a0 = acc_q.size(); d0 = done_q.size(); w0 = wr_addr_q.size(); e0 = start_q.size();
    exp_clear = 1'b0;
    @(posedge clk); #1;
    drive_cmd(1'b0, s1);
    bus.cmd_valid = 1'b1;
    t1 = -1;
    for (int k = 0; k < 50 && t1 < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) t1 = cyc;
    end
    @(posedge clk); #1;
    drive_cmd(1'b0, s2);
    while (cyc < t1 + 300) @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    t2 = -1;
    for (int k = 0; k < 1500 && t2 < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) t2 = cyc;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("b2b_second_accept_gap", t2 - t1, 1027);
    while (cyc < t2 + 1027) @(negedge clk);
    chk("b2b_accept_count", acc_q.size() - a0, 2);
    chk("b2b_start_count", start_q.size() - e0, 2);
    chk("b2b_done_count", done_q.size() - d0, 2);
    exp_addr.delete(); exp_cov.delete(); exp_cyc.delete();
    add_expected(1'b0, s1, t1, 32'h7fff_ffff);
    add_expected(1'b0, s2, t2, 32'h7fff_ffff);
    check_writes("b2b", w0);

    // reset in the middle of a scan
    s1 = '0;
    s1.w0 = 32'sd10000; s1.w1 = 32'sd10000; s1.w2 = 32'sd10000;   // full coverage
    d0 = done_q.size(); w0 = wr_addr_q.size();
    issue(1'b0, s1, t1);
    while (cyc < t1 + 500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.cmd_ready, 1);
    chk("midrst_wr_en", bus.wr_en, 0);
    chk("midrst_enable", bus.rs_enable, 0);
    chk("midrst_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    chk("midrst_no_done", done_q.size() - d0, 0);
    exp_addr.delete(); exp_cov.delete(); exp_cyc.delete();
    add_expected(1'b0, s1, t1, t1 + 500);
    check_writes("midrst", w0);
    // coefficients reloaded by the next command
    run_single("after_rst", 1'b0, s_tri);

    repeat (5) @(negedge clk);
`ifdef RASTER_PERF_EN
    chk("perf_tris", perf_tris, tally_tris);
    chk("perf_px", perf_px, tally_px);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
